// File: rtl/sort_run_ctrl_if.sv
// Bundle of the sequencer's datapath-facing ports: source read port, sorter load/start/done,
// sorted output stream and destination write port. "master" is the sequencer side.
interface sort_run_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    src_addr_o;
  logic [WIDTH-1:0] src_data_i;

  logic             load_valid_o;
  logic [WIDTH-1:0] load_data_o;
  logic             load_ready_i;

  logic             sort_start_o;
  logic             sort_done_i;

  logic             out_valid_i;
  logic [WIDTH-1:0] out_data_i;
  logic             out_ready_o;

  logic             dst_we_o;
  logic [AW-1:0]    dst_addr_o;
  logic [WIDTH-1:0] dst_data_o;

  modport master (
    output src_addr_o,
    input  src_data_i,
    output load_valid_o, load_data_o,
    input  load_ready_i,
    output sort_start_o,
    input  sort_done_i,
    input  out_valid_i, out_data_i,
    output out_ready_o,
    output dst_we_o, dst_addr_o, dst_data_o
  );

  modport slave (
    input  src_addr_o,
    output src_data_i,
    input  load_valid_o, load_data_o,
    output load_ready_i,
    input  sort_start_o,
    output sort_done_i,
    output out_valid_i, out_data_i,
    input  out_ready_o,
    input  dst_we_o, dst_addr_o, dst_data_o
  );
endinterface

// File: rtl/sort_run_ctrl.sv
// Run sequencer for the sorting accelerator: loads DEPTH elements into the sorter, triggers it,
// drains the sorted stream into the destination buffer and checks that it is ascending.
module sort_run_ctrl #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               reset_ni,
  input  logic               start_i,
  sort_run_ctrl_if.master    bus,
  output logic               busy_o,
  output logic               done_o,
  output logic [1:0]         err_code_o,
  output logic [31:0]        cycles_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_CAPT, S_LOAD, S_SORT, S_DRAIN, S_DONE, S_ERR
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_TIMEOUT = 2'b01,
    ERR_ORDER   = 2'b10
  } err_t;

  state_t           state;
  logic [AW-1:0]    idx;
  logic [TW-1:0]    wait_cnt;
  logic [WIDTH-1:0] prev_data;
  logic             load_valid_q;
  logic [WIDTH-1:0] load_data_q;
  logic             sort_start_q;
  logic             out_ready_q;

  logic             accept;
  logic             last_idx;
  logic [TW-1:0]    wait_nxt;

  // out_ready_q is only ever set in DRAIN, so accept cannot fire in any other state.
  assign accept   = out_ready_q && bus.out_valid_i;
  assign last_idx = (idx == LAST_IDX);
  assign wait_nxt = wait_cnt + TW'(1);

  assign bus.src_addr_o   = idx;
  assign bus.load_valid_o = load_valid_q;
  assign bus.load_data_o  = load_data_q;
  assign bus.sort_start_o = sort_start_q;
  assign bus.out_ready_o  = out_ready_q;

  // Destination write is combinational off the accepted element; address and data are forced
  // to zero when no write is happening so the port reads all-zero while idle or in reset.
  assign bus.dst_we_o   = accept;
  assign bus.dst_addr_o = accept ? idx : '0;
  assign bus.dst_data_o = accept ? bus.out_data_i : '0;

  // NOTE: sequential state uses non-blocking assignments only, so every read in this block sees
  // the pre-edge value and later assignments in the same branch simply override earlier ones.
  always_ff @(posedge clk) begin
    if (!reset_ni) begin
      state        <= S_IDLE;
      idx          <= '0;
      wait_cnt     <= '0;
      prev_data    <= '0;
      load_valid_q <= 1'b0;
      load_data_q  <= '0;
      sort_start_q <= 1'b0;
      out_ready_q  <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      err_code_o   <= ERR_NONE;
      cycles_o     <= '0;
    end else begin
      if (busy_o && (cycles_o != '1)) begin
        cycles_o <= cycles_o + 32'd1;
      end
      sort_start_q <= 1'b0;

      unique case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start_i) begin
            state      <= S_FETCH;
            idx        <= '0;
            done_o     <= 1'b0;
            err_code_o <= ERR_NONE;
            cycles_o   <= '0;
            busy_o     <= 1'b1;
          end
        end

        S_FETCH: state <= S_CAPT;

        // Source read data is valid one cycle after the address was presented in FETCH.
        S_CAPT: begin
          load_data_q  <= bus.src_data_i;
          load_valid_q <= 1'b1;
          state        <= S_LOAD;
        end

        S_LOAD: begin
          if (bus.load_ready_i) begin
            load_valid_q <= 1'b0;
            if (last_idx) begin
              state        <= S_SORT;
              sort_start_q <= 1'b1;
              wait_cnt     <= '0;
            end else begin
              idx   <= idx + AW'(1);
              state <= S_FETCH;
            end
          end
        end

        // sort_start_q is high only on the first SORT cycle; done is ignored there because a
        // sorter may still be presenting the previous run's completion.
        S_SORT: begin
          if (!sort_start_q && bus.sort_done_i) begin
            state       <= S_DRAIN;
            idx         <= '0;
            out_ready_q <= 1'b1;
          end else if (wait_nxt == TW'(TIMEOUT)) begin
            state      <= S_ERR;
            err_code_o <= ERR_TIMEOUT;
            busy_o     <= 1'b0;
          end else begin
            wait_cnt <= wait_nxt;
          end
        end

        S_DRAIN: begin
          if (accept) begin
            prev_data <= bus.out_data_i;
            if ((idx != '0) && (bus.out_data_i < prev_data)) begin
              err_code_o <= ERR_ORDER;
            end
            if (last_idx) begin
              state       <= S_DONE;
              out_ready_q <= 1'b0;
              done_o      <= 1'b1;
              busy_o      <= 1'b0;
            end else begin
              idx <= idx + AW'(1);
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_run_ctrl.sv
// Scoreboard bench for sort_run_ctrl: directed runs push expected loads, writes and run status;
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_sort_run_ctrl;

  localparam int WIDTH   = 8;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;
  localparam int AW      = $clog2(DEPTH);

  typedef logic [WIDTH-1:0] vec_t [DEPTH];

  typedef struct packed {
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
  } wr_t;

  typedef struct {
    logic        done;
    logic [1:0]  err;
    logic [31:0] cycles;
    int          starts;
    int          writes;
  } status_t;

  logic        clk = 1'b0;
  logic        reset_ni = 1'b0;
  logic        start_i = 1'b0;
  logic        busy, done;
  logic [1:0]  err;
  logic [31:0] cycles;

  sort_run_ctrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  sort_run_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset_ni   (reset_ni),
    .start_i    (start_i),
    .bus        (bus),
    .busy_o     (busy),
    .done_o     (done),
    .err_code_o (err),
    .cycles_o   (cycles)
  );

  always #5 clk = ~clk;

  // Scoreboard queues and counters
  logic [WIDTH-1:0] exp_load[$];
  wr_t              exp_wr[$];
  status_t          exp_st[$];
  int n_vec = 0;
  int n_err = 0;

  // Environment model state
  logic [WIDTH-1:0] src_mem [DEPTH];
  logic [WIDTH-1:0] sorted  [DEPTH];
  logic [AW-1:0]    src_addr_q = '0;
  bit               timeout_mode = 1'b0;
  int               stall_idx = 1;
  int               stall_left = 0;
  int               out_k = 0;
  bit               out_hs = 1'b0;
  int               ld_seen = 0;
  bit               abort_run = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string msg);
    n_vec++;
    n_err++;
    $display("FAIL %s: %s", name, msg);
  endtask

  // Source RAM (1-cycle read latency), sorter model and load backpressure, driven just after posedge.
  initial begin
    bus.src_data_i   = '0;
    bus.load_ready_i = 1'b1;
    bus.sort_done_i  = 1'b0;
    bus.out_valid_i  = 1'b0;
    bus.out_data_i   = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.src_data_i = src_mem[src_addr_q];
      if (bus.sort_start_o) begin
        out_k           = 0;
        bus.sort_done_i = !timeout_mode;
        bus.out_valid_i = !timeout_mode;
      end else if (out_hs && out_k < DEPTH - 1) begin
        out_k++;
      end
      bus.out_data_i = sorted[out_k];
      if (stall_left > 0 && bus.load_valid_o && ld_seen == stall_idx) begin
        bus.load_ready_i = 1'b0;
        stall_left--;
      end else begin
        bus.load_ready_i = 1'b1;
      end
    end
  end

  // Monitor: samples at negedge, pops expectations as the DUT produces them.
  logic             busy_q = 1'b0;
  logic             stall_q = 1'b0;
  logic [WIDTH-1:0] stall_data_q = '0;
  int               n_starts = 0;
  int               n_wr = 0;
  wr_t              w;
  status_t          s;

  always @(negedge clk) begin
    src_addr_q = bus.src_addr_o;
    out_hs     = bus.out_valid_i && bus.out_ready_o;
    if (busy === 1'b1 && !busy_q) begin
      ld_seen  = 0;
      n_starts = 0;
      n_wr     = 0;
    end
    if (bus.sort_start_o === 1'b1) n_starts++;

    if (stall_q && !abort_run) begin
      check("stall/load_valid", bus.load_valid_o, 1);
      check("stall/load_data", bus.load_data_o, stall_data_q);
    end
    stall_q      = (bus.load_valid_o === 1'b1) && (bus.load_ready_i === 1'b0);
    stall_data_q = bus.load_data_o;

    if (bus.load_valid_o === 1'b1 && bus.load_ready_i === 1'b1) begin
      ld_seen++;
      if (exp_load.size() == 0) fail("load", $sformatf("unexpected load of %0d", bus.load_data_o));
      else check("load/data", bus.load_data_o, exp_load.pop_front());
    end

    if (bus.dst_we_o === 1'b1) begin
      n_wr++;
      check("dst/we_needs_handshake", bus.out_ready_o && bus.out_valid_i, 1);
      if (exp_wr.size() == 0) begin
        fail("dst", $sformatf("unexpected write addr %0d data %0d", bus.dst_addr_o, bus.dst_data_o));
      end else begin
        w = exp_wr.pop_front();
        check("dst/addr", bus.dst_addr_o, w.addr);
        check("dst/data", bus.dst_data_o, w.data);
      end
    end

    if (busy === 1'b0 && busy_q) begin
      if (abort_run) begin
        abort_run = 1'b0;
      end else if (exp_st.size() == 0) begin
        fail("status", "run ended with no expected status");
      end else begin
        s = exp_st.pop_front();
        check("status/done", done, s.done);
        check("status/err", err, s.err);
        check("status/cycles", cycles, s.cycles);
        check("status/sort_starts", n_starts, s.starts);
        check("status/writes", n_wr, s.writes);
      end
    end
    busy_q = (busy === 1'b1);
  end

  task automatic check_zero(input string tag);
    check({tag, "/busy"}, busy, 0);
    check({tag, "/done"}, done, 0);
    check({tag, "/err"}, err, 0);
    check({tag, "/cycles"}, cycles, 0);
    check({tag, "/src_addr"}, bus.src_addr_o, 0);
    check({tag, "/load_valid"}, bus.load_valid_o, 0);
    check({tag, "/load_data"}, bus.load_data_o, 0);
    check({tag, "/sort_start"}, bus.sort_start_o, 0);
    check({tag, "/out_ready"}, bus.out_ready_o, 0);
    check({tag, "/dst_we"}, bus.dst_we_o, 0);
    check({tag, "/dst_addr"}, bus.dst_addr_o, 0);
    check({tag, "/dst_data"}, bus.dst_data_o, 0);
  endtask

  // One complete run. Called and returns at a negedge.
  task automatic do_run(input string tag, input vec_t src, input vec_t srt, input int stall,
                        input bit tmo, input bit poke_start, input logic [1:0] exp_err,
                        input int exp_cyc);
    status_t st;
    wr_t     wx;
    for (int i = 0; i < DEPTH; i++) begin
      src_mem[i] = src[i];
      sorted[i]  = srt[i];
      exp_load.push_back(src[i]);
      if (!tmo) begin
        wx.addr = AW'(i);
        wx.data = srt[i];
        exp_wr.push_back(wx);
      end
    end
    st.done   = !tmo;
    st.err    = exp_err;
    st.cycles = exp_cyc;
    st.starts = 1;
    st.writes = tmo ? 0 : DEPTH;
    exp_st.push_back(st);
    stall_idx    = 1;
    stall_left   = stall;
    timeout_mode = tmo;

    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    check({tag, "/fetch_busy"}, busy, 1);
    check({tag, "/fetch_done_cleared"}, done, 0);
    check({tag, "/fetch_err_cleared"}, err, 0);
    check({tag, "/fetch_cycles_cleared"}, cycles, 0);

    if (poke_start) begin
      int c;
      c = 0;
      while (bus.sort_start_o !== 1'b1 && c < 100) begin
        @(negedge clk);
        c++;
      end
      if (bus.sort_start_o !== 1'b1) fail({tag, "/wait_sort_start"}, "no sort_start within 100 cycles");
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
    end

    for (int c = 0; c < 400 && exp_st.size() != 0; c++) @(negedge clk);
    if (exp_st.size() != 0) begin
      fail({tag, "/run_end"}, "busy did not fall within 400 cycles");
      exp_st.delete();
    end
    check({tag, "/loads_left"}, exp_load.size(), 0);
    check({tag, "/writes_left"}, exp_wr.size(), 0);
    exp_load.delete();
    exp_wr.delete();

    repeat (3) @(negedge clk);
    check({tag, "/hold_cycles"}, cycles, exp_cyc);
    check({tag, "/hold_err"}, err, exp_err);
    check({tag, "/hold_done"}, done, !tmo);
    check({tag, "/hold_busy"}, busy, 0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      src_mem[i] = '0;
      sorted[i]  = '0;
    end
    reset_ni = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset_ni = 1'b1;
    @(negedge clk);
    check_zero("idle");

    // Normal run: 3*4 + 2 + 4 = 18 cycles
    do_run("normal", '{8'd3, 8'd1, 8'd2, 8'd0}, '{8'd0, 8'd1, 8'd2, 8'd3}, 0, 1'b0, 1'b0, 2'b00, 18);
    // Different data including both ends of the unsigned range
    do_run("extremes", '{8'd200, 8'd7, 8'd255, 8'd0}, '{8'd0, 8'd7, 8'd200, 8'd255}, 0, 1'b0, 1'b0, 2'b00, 18);
    // Five stall cycles on element 1
    do_run("backpressure", '{8'd3, 8'd1, 8'd2, 8'd0}, '{8'd0, 8'd1, 8'd2, 8'd3}, 5, 1'b0, 1'b0, 2'b00, 23);
    // Out-of-order sorter output still drains all four elements
    do_run("order", '{8'd3, 8'd1, 8'd2, 8'd0}, '{8'd0, 8'd2, 8'd1, 8'd3}, 0, 1'b0, 1'b0, 2'b10, 18);
    // No sort_done: 12 load cycles + 16 SORT cycles, then ERR
    do_run("timeout", '{8'd5, 8'd9, 8'd1, 8'd4}, '{8'd1, 8'd4, 8'd5, 8'd9}, 0, 1'b1, 1'b0, 2'b01, 28);
    // Fresh run out of ERR clears the error code
    do_run("after_err", '{8'd5, 8'd9, 8'd1, 8'd4}, '{8'd1, 8'd4, 8'd5, 8'd9}, 0, 1'b0, 1'b0, 2'b00, 18);
    // start_i pulsed during SORT has no effect
    do_run("start_busy", '{8'd3, 8'd1, 8'd2, 8'd0}, '{8'd0, 8'd1, 8'd2, 8'd3}, 0, 1'b0, 1'b1, 2'b00, 18);

    // Reset while stalled in LOAD with idx = 2
    src_mem = '{8'd3, 8'd1, 8'd2, 8'd0};
    sorted  = '{8'd0, 8'd1, 8'd2, 8'd3};
    exp_load.push_back(8'd3);
    exp_load.push_back(8'd1);
    exp_load.push_back(8'd2);
    stall_idx    = 2;
    stall_left   = 3;
    timeout_mode = 1'b0;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    begin
      int c;
      c = 0;
      while (!(bus.load_valid_o === 1'b1 && bus.load_ready_i === 1'b0 && bus.src_addr_o == AW'(2)) && c < 100) begin
        @(negedge clk);
        c++;
      end
      if (c >= 100) fail("midrun/reach_load2", "LOAD of element 2 not reached within 100 cycles");
    end
    check("midrun/load_data_before_reset", bus.load_data_o, 2);
    abort_run = 1'b1;
    reset_ni  = 1'b0;
    @(negedge clk);
    reset_ni   = 1'b1;
    stall_left = 0;
    check_zero("midrun_reset");
    exp_load.delete();
    @(negedge clk);
    check("midrun/stays_idle", busy, 0);

    // Recovery after reset
    do_run("post_reset", '{8'd200, 8'd7, 8'd255, 8'd0}, '{8'd0, 8'd7, 8'd200, 8'd255}, 0, 1'b0, 1'b0, 2'b00, 18);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sort_run_ctrl.md
# sort_run_ctrl

Run sequencer for the sorting accelerator on the ULX3S top. On a start request it streams `DEPTH` elements from a source buffer into the sorter core, then pulses the sorter's start input and waits for completion. It then drains the sorted stream into a destination buffer, checks ascending order and reports status and run length. It sits between the button/LED glue in `ulx3s` and the sorter datapath; `start_i` is driven by the debounced `btn[1]`.

## Interface
- `WIDTH`, 8: element width in bits
- `DEPTH`, 8: elements per run; power of two, ≥2
- `TIMEOUT`, 1024: maximum cycles spent in SORT waiting for `sort_done_i`
- `clk` in 1: single clock, all logic on posedge
- `reset_ni` in 1: reset is synchronous and active-low
- `start_i` in 1: start request, sampled in IDLE, DONE and ERR only
- `src_addr_o` out $clog2(DEPTH): source buffer read address; read latency is exactly 1 cycle
- `src_data_i` in WIDTH: source read data
- `load_valid_o` out 1, `load_data_o` out WIDTH, `load_ready_i` in 1: element load into the sorter (valid/ready)
- `sort_start_o` out 1: one-cycle pulse to begin sorting
- `sort_done_i` in 1: sorter finished, level-sampled
- `out_valid_i` in 1, `out_data_i` in WIDTH, `out_ready_o` out 1: sorted stream from the sorter
- `dst_we_o` out 1, `dst_addr_o` out $clog2(DEPTH), `dst_data_o` out WIDTH: destination buffer write port
- `busy_o` out 1: high in every state except IDLE, DONE and ERR
- `done_o` out 1: run completed, held until the next accepted start
- `err_code_o` out 2: 00 = none, 01 = sort timeout, 10 = order violation
- `cycles_o` out 32: run length counter, saturating

## Operation
- States: IDLE, FETCH, CAPT, LOAD, SORT, DRAIN, DONE, ERR.
- Entering FETCH from IDLE/DONE/ERR (on `start_i`=1):
  - clear `idx`, `done_o`, `err_code_o` and `cycles_o`.
- FETCH:
  - drive `src_addr_o`=`idx`.
  - Go to CAPT.
- CAPT:
  - register `src_data_i` into `load_data_o`.
  - Go to LOAD.
- LOAD:
  - `load_valid_o`=1.
  - `load_data_o` holds stable until `load_valid_o` && `load_ready_i`.
  - On handshake: if `idx`==DEPTH-1, go to SORT; otherwise increment `idx` and go to FETCH.
- SORT:
  - `sort_start_o`=1 on the first SORT cycle only.
  - The wait counter starts at 0 and increments each SORT cycle while `sort_done_i`=0.
  - `sort_done_i`=1 (checked from the second SORT cycle onward): go to DRAIN with `idx`=0.
  - Counter reaches TIMEOUT: go to ERR with `err_code_o`=01.
- DRAIN:
  - `out_ready_o`=1 while fewer than DEPTH elements have been accepted.
  - Each accepted element drives `dst_we_o`=1, `dst_addr_o`=`idx`, `dst_data_o`=`out_data_i`, combinationally in the same cycle.
  - For `idx`>0, if `out_data_i` < the previously accepted element (unsigned compare), set `err_code_o`=10 (sticky).
  - Drain always completes. After element DEPTH-1 is accepted, go to DONE.
- DONE:
  - `done_o`=1.
  - `start_i` starts a new run; `out_valid_i` is ignored (`out_ready_o`=0).
- ERR:
  - outputs hold.
  - Exit only via `start_i` (new run) or reset.
- `start_i` in FETCH..DRAIN is ignored.
- `cycles_o` increments every cycle from the first FETCH through the DRAIN cycle that accepts the last element. It freezes in DONE/ERR and saturates at 2^32-1.

## Timing
- Reset (`reset_ni`=0 at a posedge) from any state, including mid-LOAD or mid-DRAIN:
  - next state is IDLE.
  - all outputs are 0 from the following cycle: addresses, data, valid/ready, `sort_start_o`, `dst_we_o`, `busy_o`, `done_o`, `err_code_o`, `cycles_o`.
- `start_i` sampled high at posedge N: FETCH in cycle N+1; `busy_o`=1 from N+1.
- Minimum load cost is 3 cycles per element (FETCH, CAPT, LOAD with `load_ready_i`=1). Each cycle of `load_ready_i`=0 adds one.
- `sort_start_o` is asserted exactly once per run, in the cycle after the last load handshake.
- Minimum run with zero stalls and `sort_done_i` seen on the second SORT cycle: 3·DEPTH + 2 + DEPTH cycles.
- `done_o` rises in the cycle after the last DRAIN acceptance; `busy_o` falls in the same cycle.
- `dst_we_o` is never asserted outside DRAIN. Exactly DEPTH writes occur per completed run.

## Test plan
- **Reset mid-run:** assert `reset_ni`=0 for one cycle while in LOAD with `idx`=2 → next cycle IDLE, all outputs 0, `busy_o`=0.
- **Normal run:** DEPTH=4, source [3,1,2,0], sorter model returns [0,1,2,3] →
  - loads 3,1,2,0 in order.
  - one `sort_start_o` pulse.
  - writes (0,0),(1,1),(2,2),(3,3).
  - `done_o`=1, `err_code_o`=00, `cycles_o`=18 with no stalls.
- **Backpressure:** hold `load_ready_i`=0 for 5 cycles on element 1 → `load_valid_o` stays 1, `load_data_o` stays 1, `cycles_o` increases by 5.
- **Order violation:** sorter returns [0,2,1,3] → all 4 writes still occur, `done_o`=1, `err_code_o`=10.
- **Timeout:** TIMEOUT=16, `sort_done_i` held 0 →
  - ERR entered after exactly 16 SORT cycles, `err_code_o`=01, no DRAIN writes.
  - a subsequent `start_i` begins a fresh run with `err_code_o` cleared.
- **Start while busy:** pulse `start_i` during SORT → no effect; single `sort_start_o` pulse; run completes normally.
